// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory:
// a valid/ready request channel and an in-order response channel with no backpressure.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch unit side: issues requests, consumes responses
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: accepts requests, returns responses
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Issues sequential word fetches, tags each request
// with the PC and fetch epoch, buffers matching responses in a DEPTH-entry queue and
// presents the queue head to the IF/ID register. A redirect flushes the queue and
// retags everything still in flight so its responses are dropped.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master imem,
  input  logic            redirect_en,
  input  logic [31:0]     redirect_pc,
  input  logic            id_stall,
  output logic [31:0]     if_IR_out,
  output logic [31:0]     if_PC_out,
  output logic [31:0]     if_NPC_out,
  output logic            if_valid_inst_out
);
  localparam int              AW         = $clog2(DEPTH);
  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [AW+1:0]   CREDIT_MAX = (AW+2)'(DEPTH);

  // Fetch address and epoch
  logic [31:0]   r_fetch_pc;
  logic          r_epoch;

  // PC/epoch tags of requests awaiting a response, in request order
  logic [31:0]   r_tag_pc [DEPTH];
  logic          r_tag_ep [DEPTH];
  logic [AW-1:0] r_tag_wptr;
  logic [AW-1:0] r_tag_rptr;
  logic [AW:0]   r_outstanding;

  // Instruction queue feeding decode
  logic [31:0]   r_q_ir [DEPTH];
  logic [31:0]   r_q_pc [DEPTH];
  logic [AW-1:0] r_q_wptr;
  logic [AW-1:0] r_q_rptr;
  logic [AW:0]   r_occ;
  logic [31:0]   r_last_pc;

  logic [AW+1:0]    w_credit_used;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp_take;
  logic             w_rsp_live;
  logic [31:0]      w_rsp_pc;
  logic             w_q_push;
  logic             w_q_pop;
  logic             w_q_valid;
  logic [31:0]      w_head_pc;
  logic [DEPTH-1:0] w_tag_wsel;

  // Outstanding requests and buffered words together never exceed the queue size,
  // so every response is guaranteed a free slot.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_occ};
  assign w_req_valid   = !rst && !redirect_en && (w_credit_used < CREDIT_MAX);
  assign w_req_fire    = w_req_valid && imem.imem_req_ready;

  // A response with no tag waiting (e.g. for a request issued before reset) is ignored.
  assign w_rsp_take = imem.imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_pc   = r_tag_pc[r_tag_rptr];
  assign w_rsp_live = (r_tag_ep[r_tag_rptr] == r_epoch);
  assign w_q_push   = w_rsp_take && w_rsp_live && !redirect_en;

  assign w_q_valid  = (r_occ != '0);
  assign w_head_pc  = r_q_pc[r_q_rptr];
  assign w_q_pop    = w_q_valid && !id_stall && !redirect_en;

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_fetch_pc;

  assign if_valid_inst_out = w_q_valid;
  assign if_IR_out         = w_q_valid ? r_q_ir[r_q_rptr] : NOP;
  assign if_PC_out         = w_q_valid ? w_head_pc : r_last_pc;
  assign if_NPC_out        = if_PC_out + 32'd4;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag_wsel
      assign w_tag_wsel[gi] = w_req_fire && (r_tag_wptr == AW'(gi));
    end
  endgenerate

  // Control state: fetch PC, epoch, pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_epoch       <= 1'b0;
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_outstanding <= '0;
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
      r_occ         <= '0;
      r_last_pc     <= 32'h0;
    end else begin
      if (w_q_valid) begin
        r_last_pc <= w_head_pc;
      end

      if (redirect_en) begin
        r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        r_epoch    <= ~r_epoch;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (w_req_fire) begin
        r_tag_wptr <= r_tag_wptr + AW'(1);
      end
      if (w_rsp_take) begin
        r_tag_rptr <= r_tag_rptr + AW'(1);
      end
      case ({w_req_fire, w_rsp_take})
        2'b10:   r_outstanding <= r_outstanding + (AW+1)'(1);
        2'b01:   r_outstanding <= r_outstanding - (AW+1)'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (redirect_en) begin
        r_q_wptr <= '0;
        r_q_rptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_q_push) begin
          r_q_wptr <= r_q_wptr + AW'(1);
        end
        if (w_q_pop) begin
          r_q_rptr <= r_q_rptr + AW'(1);
        end
        case ({w_q_push, w_q_pop})
          2'b10:   r_occ <= r_occ + (AW+1)'(1);
          2'b01:   r_occ <= r_occ - (AW+1)'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  // Tag storage: new requests record PC and epoch; a redirect stamps every entry with
  // the epoch being retired so none can match the new one, even after two toggles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_tag_wsel[i]) begin
        r_tag_pc[i] <= r_fetch_pc;
        r_tag_ep[i] <= r_epoch;
      end else if (redirect_en) begin
        r_tag_ep[i] <= r_epoch;
      end
    end
  end

  // Instruction queue storage: accepted responses written at the tail
  always_ff @(posedge clk) begin
    if (w_q_push) begin
      r_q_ir[r_q_wptr] <= imem.imem_rsp_data;
      r_q_pc[r_q_wptr] <= w_rsp_pc;
    end
  end
endmodule
